// File: rtl/pbit_adder_sequencer.sv
// Run sequencer for a stochastic p-bit ripple adder: flush, settle, sample
// STEPS cycles of adder outputs into per-bit counters, then majority-vote.
module pbit_adder_sequencer #(
  parameter int STEPS   = 1000,
  parameter int BURN_IN = 2,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] op_mode,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  input  logic [3:0] op_sum,
  input  logic [3:0] op_i0,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] result_a,
  output logic [3:0] result_b,
  output logic [3:0] result_sum,
  output logic       result_ovf,
  output logic       adder_reset,
  output logic [1:0] adder_mode,
  output logic [3:0] adder_I_0,
  output logic [3:0] adder_a,
  output logic [3:0] adder_b,
  output logic [3:0] adder_sum,
  input  logic [3:0] a_out,
  input  logic [3:0] b_out,
  input  logic [3:0] sum_out,
  input  logic       overflow
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DECIDE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int unsigned NCNT = 13;
  localparam int          PW   = $clog2(STEPS + BURN_IN + 1) + 1;

  state_t           state_q, state_d;
  logic [PW-1:0]    cyc_q, cyc_d;
  logic [1:0]       mode_q;
  logic [3:0]       a_q, b_q, sum_q, i0_q;
  logic [CNT_W-1:0] cnt_q [NCNT];
  logic [NCNT-1:0]  res_q;
  logic [NCNT-1:0]  vote;
  logic [NCNT-1:0]  samp;
  logic             error_q;
  logic             accept;

  // Counter index map: [3:0] a, [7:4] b, [11:8] sum, [12] overflow.
  assign samp   = {overflow, sum_out, b_out, a_out};
  assign accept = (state_q == S_IDLE) && start && (op_mode != 2'd3);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        cyc_d   = '0;
        state_d = (BURN_IN == 0) ? S_SAMPLE : S_SETTLE;
        if (abort) state_d = S_IDLE;
      end
      S_SETTLE: begin
        cyc_d = cyc_q + PW'(1);
        if (cyc_q + PW'(1) == PW'(BURN_IN)) begin
          cyc_d   = '0;
          state_d = S_SAMPLE;
        end
        if (abort) state_d = S_IDLE;
      end
      S_SAMPLE: begin
        cyc_d = cyc_q + PW'(1);
        if (cyc_q + PW'(1) == PW'(STEPS)) begin
          cyc_d   = '0;
          state_d = S_DECIDE;
        end
        if (abort) state_d = S_IDLE;
      end
      S_DECIDE: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strict majority: a tie (2*count == STEPS) votes 0.
  always_comb begin
    vote = '0;
    for (int unsigned i = 0; i < NCNT; i++) begin
      vote[i] = ({1'b0, cnt_q[i]} << 1) > (CNT_W+1)'(STEPS);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      mode_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      i0_q    <= '0;
      res_q   <= '0;
      error_q <= 1'b0;
      for (int unsigned i = 0; i < NCNT; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      error_q <= (state_q == S_IDLE) && start && (op_mode == 2'd3);
      if (accept) begin
        mode_q <= op_mode;
        a_q    <= op_a;
        b_q    <= op_b;
        sum_q  <= op_sum;
        i0_q   <= op_i0;
      end
      if (state_q == S_FLUSH) begin
        for (int unsigned i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      end
      if (state_q == S_SAMPLE) begin
        for (int unsigned i = 0; i < NCNT; i++) begin
          if (samp[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
      if (state_q == S_DECIDE) res_q <= vote;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign error       = error_q;
  assign adder_reset = (state_q == S_IDLE) || (state_q == S_FLUSH);
  assign adder_mode  = mode_q;
  assign adder_a     = a_q;
  assign adder_b     = b_q;
  assign adder_sum   = sum_q;
  assign adder_I_0   = i0_q;
  assign result_a    = res_q[3:0];
  assign result_b    = res_q[7:4];
  assign result_sum  = res_q[11:8];
  assign result_ovf  = res_q[12];

endmodule

// File: tb/tb_pbit_adder_sequencer.sv
// Directed bench for pbit_adder_sequencer with a deterministic stub adder
// (STEPS=16, BURN_IN=2); start is driven after edge k and captured at k+1.
module tb_pbit_adder_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [1:0] op_mode;
  logic [3:0] op_a, op_b, op_sum, op_i0;
  logic       busy, done, error;
  logic [3:0] result_a, result_b, result_sum;
  logic       result_ovf;
  logic       adder_reset;
  logic [1:0] adder_mode;
  logic [3:0] adder_I_0, adder_a, adder_b, adder_sum;
  logic [3:0] a_out, b_out, sum_out;
  logic       overflow;

  logic       tie_en   = 1'b0;
  logic       tog      = 1'b0;
  logic [3:0] stub_sum = '0;
  logic       stub_ovf = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int lat, busy_n, done_n;

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  // Stub adder: echoes latched a/b, fixed sum/overflow, optional b[0] toggle.
  assign a_out    = adder_a;
  assign b_out    = tie_en ? {3'b111, tog} : adder_b;
  assign sum_out  = stub_sum;
  assign overflow = stub_ovf;

  pbit_adder_sequencer #(.STEPS(16), .BURN_IN(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .op_mode(op_mode),
    .op_a(op_a), .op_b(op_b), .op_sum(op_sum), .op_i0(op_i0),
    .busy(busy), .done(done), .error(error),
    .result_a(result_a), .result_b(result_b), .result_sum(result_sum),
    .result_ovf(result_ovf), .adder_reset(adder_reset), .adder_mode(adder_mode),
    .adder_I_0(adder_I_0), .adder_a(adder_a), .adder_b(adder_b),
    .adder_sum(adder_sum), .a_out(a_out), .b_out(b_out), .sum_out(sum_out),
    .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller has driven start=1 just after an edge; t counts edges from there.
  task automatic run(input int start2_at, input int abort_at,
                     output int l, output int bn, output int dn);
    l = 0; bn = 0; dn = 0;
    for (int t = 1; t <= 45; t++) begin
      @(posedge clk); #1;
      if (busy) bn++;
      if (done) begin
        dn++;
        if (l == 0) l = t;
      end
      start = (t == start2_at);
      if (t == start2_at) op_a = 4'd5;
      if (t == 1) begin
        op_a = ~op_a;
        op_b = ~op_b;
      end
      abort = (t == abort_at);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; op_mode = '0;
    op_a = '0; op_b = '0; op_sum = '0; op_i0 = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_results", {result_ovf, result_sum, result_b, result_a}, 0);
    chk("rst_adder_reset", adder_reset, 1);
    chk("rst_adder_ops", {adder_mode, adder_I_0, adder_a, adder_b, adder_sum}, 0);
    @(posedge clk); @(posedge clk); #1;

    // Forward run, start on first edge after reset release
    reset = 1'b0;
    op_mode = 2'd0; op_a = 4'd1; op_b = 4'd7; op_sum = 4'd0; op_i0 = 4'd0;
    stub_sum = 4'd8; stub_ovf = 1'b0; tie_en = 1'b0; start = 1'b1;
    run(0, 0, lat, busy_n, done_n);
    chk("fwd_latency", lat, 21);
    chk("fwd_busy_cycles", busy_n, 21);
    chk("fwd_done_count", done_n, 1);
    chk("fwd_result_sum", result_sum, 4'd8);
    chk("fwd_result_ovf", result_ovf, 0);
    chk("fwd_result_a", result_a, 4'd1);
    chk("fwd_result_b", result_b, 4'd7);
    chk("fwd_adder_a_latched", adder_a, 4'd1);
    chk("fwd_idle_adder_reset", adder_reset, 1);

    // Tie vote on b[0], overflow always 1
    op_mode = 2'd1; op_a = 4'd2; op_b = 4'd0; op_sum = 4'd3; op_i0 = 4'd1;
    stub_sum = 4'd3; stub_ovf = 1'b1; tie_en = 1'b1; start = 1'b1;
    run(0, 0, lat, busy_n, done_n);
    chk("tie_done_count", done_n, 1);
    chk("tie_result_b", result_b, 4'b1110);
    chk("tie_result_a", result_a, 4'd2);
    chk("tie_result_sum", result_sum, 4'd3);
    chk("tie_result_ovf", result_ovf, 1);
    chk("tie_adder_mode", adder_mode, 2'd1);
    chk("tie_adder_i0", adder_I_0, 4'd1);
    tie_en = 1'b0;

    // Abort in the 5th SAMPLE cycle: results stay from the tie run
    op_mode = 2'd2; op_a = 4'd3; op_b = 4'd0; op_sum = 4'd12; op_i0 = 4'd0;
    stub_sum = 4'd12; stub_ovf = 1'b0; start = 1'b1;
    run(0, 8, lat, busy_n, done_n);
    chk("abort_done_count", done_n, 0);
    chk("abort_busy_cycles", busy_n, 8);
    chk("abort_results_held", {result_ovf, result_sum, result_b, result_a}, {1'b1, 4'd3, 4'b1110, 4'd2});

    // Start and abort together in IDLE, then abort during DECIDE
    op_mode = 2'd0; op_a = 4'd6; op_b = 4'd9; op_sum = 4'd0; op_i0 = 4'd0;
    stub_sum = 4'd15; stub_ovf = 1'b0; start = 1'b1; abort = 1'b1;
    run(0, 20, lat, busy_n, done_n);
    chk("abtidle_latency", lat, 21);
    chk("abtidle_done_count", done_n, 1);
    chk("abtidle_results", {result_ovf, result_sum, result_b, result_a}, {1'b0, 4'd15, 4'd9, 4'd6});

    // Illegal mode
    op_mode = 2'd3; op_a = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    chk("illegal_error_pulse", error, 1);
    chk("illegal_busy", busy, 0);
    chk("illegal_adder_reset", adder_reset, 1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("illegal_error_cleared", error, 0);
    chk("illegal_busy_after", busy, 0);
    chk("illegal_adder_a_kept", adder_a, 4'd6);

    // Asynchronous reset during SETTLE
    op_mode = 2'd0; op_a = 4'd4; op_b = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    chk("midrst_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_results", {result_ovf, result_sum, result_b, result_a}, 0);
    chk("midrst_adder", {adder_reset, adder_a, adder_b}, {1'b1, 8'h00});
    @(posedge clk); #1;
    reset = 1'b0;

    // Second start during SAMPLE is ignored
    op_mode = 2'd0; op_a = 4'd1; op_b = 4'd2; op_sum = 4'd0; op_i0 = 4'd0;
    stub_sum = 4'd3; stub_ovf = 1'b0; start = 1'b1;
    run(10, 0, lat, busy_n, done_n);
    chk("busy2_latency", lat, 21);
    chk("busy2_busy_cycles", busy_n, 21);
    chk("busy2_done_count", done_n, 1);
    chk("busy2_result_a", result_a, 4'd1);
    chk("busy2_result_b_sum", {result_b, result_sum}, {4'd2, 4'd3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
